a_n_csub_seq: RTL and testbench



---
 rtl/a_n_csub_seq_pkg.sv | 20 ++
 rtl/a_n_csub_seq_if.sv | 28 ++
 rtl/a_n_csub_seq_fullsub.sv | 16 +
 rtl/a_n_csub_seq.sv | 118 +++++++++++
 tb/tb_a_n_csub_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/a_n_csub_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle borrow-skip subtractor.
package a_n_csub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned M_DEF = 4;
  localparam int unsigned K_DEF = 2;

  // Group counter width; a single group still needs one index bit.
  function automatic int unsigned idx_w(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  localparam int unsigned IW_DEF = idx_w(K_DEF);

endpackage

// File: rtl/a_n_csub_seq_if.sv
// Start/ready/done request bus and result bus of the sequential subtractor.
interface a_n_csub_seq_if #(
  parameter int unsigned m = 4,
  parameter int unsigned k = 2
);
  localparam int unsigned n = m * k;

  logic         start;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         borrowin;
  logic         ready;
  logic         busy;
  logic [n-1:0] diff;
  logic [k-1:0] borrowout;
  logic [k-1:0] skipped;
  logic         done;

  modport master (
    output start, a, b, borrowin,
    input  ready, busy, diff, borrowout, skipped, done
  );

  modport slave (
    input  start, a, b, borrowin,
    output ready, busy, diff, borrowout, skipped, done
  );
endinterface

// File: rtl/a_n_csub_seq_fullsub.sv
// One-bit full subtractor that also exposes its borrow-propagate term.
module a_skip_fullsubtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_borrowin,
  output logic o_diff,
  output logic o_borrowout,
  output logic o_propagate
);
  logic w_x;

  assign w_x         = i_a ^ i_b;
  assign o_diff      = w_x ^ i_borrowin;
  assign o_borrowout = (~i_a & i_b) | (~w_x & i_borrowin);
  assign o_propagate = ~w_x;
endmodule

// File: rtl/a_n_csub_seq.sv
// Sequential carry-skip subtractor: one m-bit group per clock, LSB group first.
module a_n_csub_seq
  import a_n_csub_seq_pkg::*;
#(
  parameter int unsigned m = M_DEF,
  parameter int unsigned k = K_DEF
) (
  input  logic             clk,
  input  logic             reset,
  a_n_csub_seq_if.slave    bus
);
  localparam int unsigned n  = m * k;
  localparam int unsigned IW = idx_w(k);

  state_t          r_state;
  state_t          w_next;
  logic [n-1:0]    r_a;
  logic [n-1:0]    r_b;
  logic [n-1:0]    r_diff;
  logic [k-1:0]    r_bo;
  logic [k-1:0]    r_skip;
  logic [IW-1:0]   r_idx;
  logic            r_borrow;

  logic            w_accept;
  logic            w_last;
  logic [m-1:0]    w_ag;
  logic [m-1:0]    w_bg;
  logic [m-1:0]    w_dg;
  logic [m-1:0]    w_p;
  logic [m:0]      w_chain;
  logic            w_pall;
  logic            w_bout;

  // A single group datapath, reused every cycle through the group-select mux.
  assign w_ag       = r_a[r_idx*m +: m];
  assign w_bg       = r_b[r_idx*m +: m];
  assign w_chain[0] = r_borrow;

  for (genvar i = 0; i < m; i++) begin : g_bit
    a_skip_fullsubtractor u_fs (
      .i_a         (w_ag[i]),
      .i_b         (w_bg[i]),
      .i_borrowin  (w_chain[i]),
      .o_diff      (w_dg[i]),
      .o_borrowout (w_chain[i+1]),
      .o_propagate (w_p[i])
    );
  end

  // When every bit propagates the incoming borrow bypasses the ripple chain.
  assign w_pall = &w_p;
  assign w_bout = w_pall ? r_borrow : w_chain[m];
  assign w_last = (r_idx == IW'(k - 1));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_bo     <= '0;
      r_skip   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_borrow <= bus.borrowin;
      r_diff   <= '0;
      r_bo     <= '0;
      r_skip   <= '0;
      r_idx    <= '0;
    end else if (r_state == RUN) begin
      r_diff[r_idx*m +: m] <= w_dg;
      r_bo[r_idx]          <= w_bout;
      r_skip[r_idx]        <= w_pall;
      r_borrow             <= w_bout;
      if (!w_last) r_idx <= r_idx + 1'b1;
    end
  end

  assign bus.ready     = (r_state == IDLE) || (r_state == DONE);
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.diff      = r_diff;
  assign bus.borrowout = r_bo;
  assign bus.skipped   = r_skip;
endmodule

// File: tb/tb_a_n_csub_seq.sv
// Directed and random checks of the sequential borrow-skip subtractor.
module tb_a_n_csub_seq;
  localparam int unsigned M = 4;
  localparam int unsigned K = 2;
  localparam int unsigned N = M * K;

  typedef struct packed {
    logic [N-1:0] diff;
    logic [K-1:0] bo;
    logic [K-1:0] sk;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  a_n_csub_seq_if #(.m(M), .k(K)) bus ();

  a_n_csub_seq #(.m(M), .k(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    exp_t        e;
    int unsigned br;
    int unsigned ag;
    int unsigned bg;
    e  = '0;
    br = int'(bin);
    for (int unsigned g = 0; g < K; g++) begin
      ag = int'(a[g*M +: M]);
      bg = int'(b[g*M +: M]);
      e.diff[g*M +: M] = M'(ag + (1 << M) - bg - br);
      e.sk[g] = (ag == bg);
      br = (ag < bg + br) ? 1 : 0;
      e.bo[g] = br[0];
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_diff"}, 32'(bus.diff),      32'(e.diff));
    check({tag, "_bo"},   32'(bus.borrowout), 32'(e.bo));
    check({tag, "_sk"},   32'(bus.skipped),   32'(e.sk));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.ready),     32'd1);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_done"},  32'(bus.done),      32'd0);
    check({tag, "_diff"},  32'(bus.diff),      32'd0);
    check({tag, "_bo"},    32'(bus.borrowout), 32'd0);
    check({tag, "_sk"},    32'(bus.skipped),   32'd0);
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    bus.a        = a;
    bus.b        = b;
    bus.borrowin = bin;
    bus.start    = 1'b1;
    sb.push_back(model(a, b, bin));
  endtask

  // Called in the accept cycle; walks cycles 1..K+1 and checks handshake timing.
  task automatic finish_op(input string tag);
    for (int unsigned c = 1; c <= K + 1; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_busy"},  32'(bus.busy),  (c <= K) ? 32'd1 : 32'd0);
      check({tag, "_done"},  32'(bus.done),  (c == K + 1) ? 32'd1 : 32'd0);
      check({tag, "_ready"}, 32'(bus.ready), (c == K + 1) ? 32'd1 : 32'd0);
    end
    compare_pop(tag);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    @(negedge clk);
    launch(a, b, bin);
    finish_op(tag);
  endtask

  initial begin
    exp_t last;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.borrowin = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    run_op("p5a_23", 8'h5A, 8'h23, 1'b0);
    run_op("p00_01", 8'h00, 8'h01, 1'b0);
    run_op("p33_33", 8'h33, 8'h33, 1'b1);
    run_op("p80_7f", 8'h80, 8'h7F, 1'b0);
    run_op("pff_ff", 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op("rand", N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));

    // Results hold after done while idle.
    last = model(8'hC4, 8'h5E, 1'b1);
    run_op("hold_op", 8'hC4, 8'h5E, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_diff", 32'(bus.diff),      32'(last.diff));
    check("hold_bo",   32'(bus.borrowout), 32'(last.bo));
    check("hold_done", 32'(bus.done),      32'd0);

    // Start while busy is ignored, operands changing while busy have no effect.
    @(negedge clk);
    launch(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    check("ign_busy1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy2", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("ign_done", 32'(bus.done), 32'd1);
    compare_pop("ign");
    @(negedge clk);
    check("ign_nodone", 32'(bus.done),  32'd0);
    check("ign_ready",  32'(bus.ready), 32'd1);

    // Start held high: DONE goes straight back to RUN.
    @(negedge clk);
    launch(8'hC3, 8'h3C, 1'b1);
    for (int unsigned c = 1; c <= K; c++) begin
      @(negedge clk);
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      check("b2b_busy_a", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    check("b2b_done_a", 32'(bus.done), 32'd1);
    compare_pop("b2b_a");
    launch(8'h00, 8'hFF, 1'b0);
    for (int unsigned c = 1; c <= K; c++) begin
      @(negedge clk);
      bus.a = N'($urandom);
      bus.b = N'($urandom);
      check("b2b_busy_b", 32'(bus.busy),  32'd1);
      check("b2b_rdy_b",  32'(bus.ready), 32'd0);
    end
    @(negedge clk);
    check("b2b_done_b", 32'(bus.done), 32'd1);
    compare_pop("b2b_b");
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_end_done",  32'(bus.done),  32'd0);
    check("b2b_end_ready", 32'(bus.ready), 32'd1);

    // Reset mid-run aborts the operation without a done pulse.
    @(negedge clk);
    bus.a     = 8'h5A;
    bus.b     = 8'h23;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("rst_mid");
    reset = 1'b0;
    launch(8'h80, 8'h7F, 1'b0);
    finish_op("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
